// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the core's ma_* port: region codes,
// IO register offsets and the status byte layout.
package mem_map_pkg;

  typedef enum logic [1:0] {
    REG_RAM   = 2'b00,
    REG_UNMAP = 2'b10,
    REG_IO    = 2'b11
  } region_e;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  localparam logic [2:0]  IO_TX   = 3'h0;
  localparam logic [2:0]  IO_STAT = 3'h4;

  // Status byte: {overflow, 2'b00, count[4:0]}
  localparam int STAT_OVF_BIT = 7;
  localparam int STAT_CNT_W   = 5;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
    logic        rw;
    logic        ce;
  } ma_req_t;

  // addr[17:16]: 00/01 RAM, 10 unmapped, 11 IO
  function automatic region_e decode_region(input logic [1:0] sel);
    if (!sel[1])     return REG_RAM;
    else if (sel[0]) return REG_IO;
    else             return REG_UNMAP;
  endfunction

  function automatic logic [7:0] stat_byte(input logic ovf,
                                           input logic [STAT_CNT_W-1:0] cnt);
    return {ovf, 2'b00, cnt};
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with free-running wrap pointers; push on full is ignored unless a
// pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          rd_en, wr_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rd_en = pop & ~empty;
  // A pop frees the head slot this edge, so a push at full still fits.
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Byte-wide responder for the core's ma_* port: RAM, an IO window with a TX
// byte stream and status register, and registered flow control to the core.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ma_addr_in,
  input  logic [7:0]  ma_data_in,
  input  logic        ma_rw_in,
  input  logic        ma_ce_in,
  output logic [7:0]  ma_data_out,
  output logic        cpu_rdy_out,
  output logic [7:0]  tx_data_out,
  output logic        tx_valid_out,
  input  logic        tx_ready_in
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ma_req_t req;
  assign req = '{addr: ma_addr_in, data: ma_data_in, rw: ma_rw_in, ce: ma_ce_in};

  logic unused_addr_hi;
  assign unused_addr_hi = ^req.addr[31:18];

  region_e region;
  logic [2:0] io_off;
  logic wr_req, rd_req, ram_wr, tx_push_req, stat_wr;

  assign region      = decode_region(req.addr[17:16]);
  assign io_off      = req.addr[2:0];
  assign wr_req      = req.ce & req.rw;
  assign rd_req      = req.ce & ~req.rw;
  assign ram_wr      = wr_req & (region == REG_RAM);
  assign tx_push_req = wr_req & (region == REG_IO) & (io_off == IO_TX);
  assign stat_wr     = wr_req & (region == REG_IO) & (io_off == IO_STAT);

  // TX FIFO
  logic [CW-1:0] count, count_next;
  logic          full, empty, pop, push_ok, drop;

  assign pop     = tx_valid_out & tx_ready_in;
  assign push_ok = tx_push_req & (~full | pop);
  assign drop    = tx_push_req & full & ~pop;
  assign count_next = count + CW'(push_ok) - CW'(pop);
  assign tx_valid_out = ~empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .din   (req.data),
    .dout  (tx_data_out),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  logic overflow;
  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (stat_wr) overflow <= 1'b0;
  end

  // rdy drops one entry early so a push already in flight still has a slot.
  always_ff @(posedge clk) begin
    if (rst) cpu_rdy_out <= 1'b0;
    else     cpu_rdy_out <= (count_next < CW'(FIFO_DEPTH - 1));
  end

  // RAM: no reset, contents survive rst
  logic [7:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (ram_wr) mem[req.addr[ADDR_WIDTH-1:0]] <= req.data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ma_data_out <= 8'h00;
    end else if (rd_req) begin
      case (region)
        REG_RAM: ma_data_out <= mem[req.addr[ADDR_WIDTH-1:0]];
        REG_IO:  ma_data_out <= (io_off == IO_STAT)
                                ? stat_byte(overflow, STAT_CNT_W'(count)) : 8'h00;
        default: ma_data_out <= 8'h00;
      endcase
    end
  end

endmodule
